// File: rtl/xm_multdiv_latch_pkg.sv
// Shared definitions for the X/M latch with multdiv stall control:
// opcode fields, setx exception words and the latch FSM state.
package xm_multdiv_latch_pkg;

    localparam logic [4:0] OP_RTYPE = 5'd0;
    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [26:0] EXC_MULT    = 27'd4;
    localparam logic [26:0] EXC_DIV     = 27'd5;
    localparam logic [26:0] EXC_TIMEOUT = 27'd6;

    localparam logic [31:0] SETX_MULT    = {OP_SETX, EXC_MULT};
    localparam logic [31:0] SETX_DIV     = {OP_SETX, EXC_DIV};
    localparam logic [31:0] SETX_TIMEOUT = {OP_SETX, EXC_TIMEOUT};
    localparam logic [31:0] TIMEOUT_CODE = 32'd6;

    localparam int         CNT_W   = 6;
    localparam logic [5:0] CNT_MAX = 6'd63;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // R-type with an ALU op of mult or div hands the instruction to multdiv.
    function automatic logic is_multdiv(input logic [31:0] instr);
        return (instr[31:27] == OP_RTYPE) &&
               ((instr[6:2] == ALU_MULT) || (instr[6:2] == ALU_DIV));
    endfunction

endpackage

// File: rtl/xm_multdiv_latch_watchdog.sv
// Completion watchdog for an in-flight multdiv operation; only built when
// XM_MULTDIV_TIMEOUT_EN is defined.
`ifdef XM_MULTDIV_TIMEOUT_EN
module multdiv_watchdog
    import xm_multdiv_latch_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic in_busy,
    input  logic issue,
    input  logic md_ready,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A coinciding md_ready beats the timeout, so expiry requires no completion.
    always_comb begin
        expired = in_busy && !md_ready && (cnt_q >= LIMIT);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (issue) begin
            cnt_d = 6'd1;
        end else if (in_busy) begin
            if (md_ready || expired) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/xm_multdiv_latch.sv
// X/M pipeline latch that bubbles M and stalls F/D/X while a multdiv op runs.
// Optional completion watchdog enabled by defining XM_MULTDIV_TIMEOUT_EN.
module xm_multdiv_latch
    import xm_multdiv_latch_pkg::*;
#(
    parameter int          TIMEOUT = 40,
    parameter logic [31:0] NOP     = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_B,
    input  logic [31:0] md_instr,
    input  logic [31:0] md_result,
    input  logic        md_ready,
    output logic        stall,
    output logic [31:0] out_instr,
    output logic [31:0] out_O,
    output logic [31:0] out_B,
    output logic        busy
);

    if (TIMEOUT < 2 || TIMEOUT > 63) begin : g_timeout_range
        $error("xm_multdiv_latch: TIMEOUT must lie in 2..63");
    end

    md_state_e   state_q;
    md_state_e   state_d;
    logic [31:0] out_instr_q;
    logic [31:0] out_instr_d;
    logic [31:0] out_o_q;
    logic [31:0] out_o_d;
    logic [31:0] out_b_q;
    logic [31:0] out_b_d;

    logic is_md;
    logic in_busy;
    logic issue;
    logic expired;

    always_comb begin
        is_md   = is_multdiv(in_instr);
        in_busy = (state_q == ST_BUSY);
        issue   = (state_q == ST_IDLE) && is_md;
    end

`ifdef XM_MULTDIV_TIMEOUT_EN
    multdiv_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .in_busy  (in_busy),
        .issue    (issue),
        .md_ready (md_ready),
        .expired  (expired)
    );
`else
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Without the watchdog the counter is kept purely as a BUSY-length record.
    always_comb begin
        expired = 1'b0;
        cnt_d   = cnt_q;
        if (issue) begin
            cnt_d = 6'd1;
        end else if (in_busy) begin
            if (md_ready) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        out_instr_d = out_instr_q;
        out_o_d     = out_o_q;
        out_b_d     = out_b_q;
        case (state_q)
            ST_IDLE: begin
                if (is_md) begin
                    out_instr_d = NOP;
                    out_o_d     = '0;
                    out_b_d     = '0;
                    state_d     = ST_BUSY;
                end else begin
                    out_instr_d = in_instr;
                    out_o_d     = in_alu_result;
                    out_b_d     = in_B;
                end
            end
            ST_BUSY: begin
                if (md_ready) begin
                    out_instr_d = md_instr;
                    out_o_d     = md_result;
                    out_b_d     = in_B;
                    state_d     = ST_IDLE;
                end else if (expired) begin
                    out_instr_d = SETX_TIMEOUT;
                    out_o_d     = TIMEOUT_CODE;
                    out_b_d     = in_B;
                    state_d     = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            out_instr_q <= NOP;
            out_o_q     <= '0;
            out_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_instr_q <= out_instr_d;
            out_o_q     <= out_o_d;
            out_b_q     <= out_b_d;
        end
    end

    // Stall is combinational so upstream latches freeze on the same edge.
    always_comb begin
        stall = reset && (issue || (in_busy && !md_ready && !expired));
    end

    assign out_instr = out_instr_q;
    assign out_O     = out_o_q;
    assign out_B     = out_b_q;
    assign busy      = in_busy;

endmodule

// File: tb/tb_xm_multdiv_latch.sv
// Scoreboard testbench for xm_multdiv_latch; covers the watchdog path when
// XM_MULTDIV_TIMEOUT_EN is defined.
module tb_xm_multdiv_latch;

    localparam logic [31:0] NOP_W  = 32'h0000_0000;
    localparam logic [31:0] ADD_W  = 32'h0044_3000;
    localparam logic [31:0] MULT_W = 32'h0044_3018;
    localparam logic [31:0] DIV_W  = 32'h0044_301C;
    localparam logic [31:0] ADDI_W = 32'h2842_0005;
    localparam logic [31:0] FAKE_W = 32'h2800_0018;
    localparam logic [31:0] OP1_W  = 32'h0800_001C;
    localparam int          TMO    = 40;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] o;
        logic [31:0] b;
    } xm_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_instr;
    logic [31:0] in_alu_result;
    logic [31:0] in_B;
    logic [31:0] md_instr;
    logic [31:0] md_result;
    logic        md_ready;
    logic        stall;
    logic [31:0] out_instr;
    logic [31:0] out_O;
    logic [31:0] out_B;
    logic        busy;

    xm_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clock = ~clock;

    xm_multdiv_latch dut (
        .clock         (clock),
        .reset         (reset),
        .in_instr      (in_instr),
        .in_alu_result (in_alu_result),
        .in_B          (in_B),
        .md_instr      (md_instr),
        .md_result     (md_result),
        .md_ready      (md_ready),
        .stall         (stall),
        .out_instr     (out_instr),
        .out_O         (out_O),
        .out_B         (out_B),
        .busy          (busy)
    );

    task automatic drive(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] b,
                         input logic rdy, input logic [31:0] mdi, input logic [31:0] mdr);
        in_instr      = instr;
        in_alu_result = alu;
        in_B          = b;
        md_ready      = rdy;
        md_instr      = mdi;
        md_result     = mdr;
        #1;
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        xm_t got;
        reset = 1'b0;
        drive(MULT_W, 32'h1234, 32'h5678, 1'b1, DIV_W, 32'h99);
        advance();
        advance();
        got = {out_instr, out_O, out_B};
        n_checks++;
        if (got !== {NOP_W, 32'h0, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", got, {NOP_W, 32'h0, 32'h0});
        end
        n_checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got stall=%b busy=%b expected 0/0", stall, busy);
        end
        drive(NOP_W, 32'h0, 32'h0, 1'b0, NOP_W, 32'h0);
        reset = 1'b1;
    endtask

    task automatic test_alu();
        logic [31:0] tbl[5];
        logic [31:0] alu;
        logic [31:0] b;
        xm_t         e;
        tbl = '{ADD_W, FAKE_W, ADDI_W, OP1_W, ADD_W};
        for (int i = 0; i < 5; i++) begin
            alu = (i == 0) ? 32'h0000_0010 : $urandom;
            b   = $urandom;
            drive(tbl[i], alu, b, 1'b0, NOP_W, 32'h0);
            n_checks++;
            if (stall !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL alu_stall[%0d]: got %b expected 0", i, stall);
            end
            exp_q.push_back({tbl[i], alu, b});
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({out_instr, out_O, out_B} !== e) begin
                n_fail++;
                $display("[TB] FAIL alu_out[%0d]: got %h/%h/%h expected %h/%h/%h",
                         i, out_instr, out_O, out_B, e.instr, e.o, e.b);
            end
        end
    endtask

    task automatic test_mult();
        int          stall_cnt = 0;
        logic        rdy;
        logic [31:0] b = 32'hCAFE_0001;
        xm_t         e;
        for (int c = 0; c <= 17; c++) begin
            rdy = (c == 17);
            drive(MULT_W, 32'hBAD0_0000 + c, b, rdy, MULT_W, rdy ? 32'h0000_0C00 : 32'hFFFF_FFFF);
            if (stall) stall_cnt++;
            n_checks++;
            if (stall !== !rdy || busy !== (c >= 1)) begin
                n_fail++;
                $display("[TB] FAIL mult_ctrl[%0d]: got stall=%b busy=%b expected %b/%b",
                         c, stall, busy, !rdy, (c >= 1));
            end
            exp_q.push_back(rdy ? {MULT_W, 32'h0000_0C00, b} : {NOP_W, 32'h0, 32'h0});
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({out_instr, out_O, out_B} !== e) begin
                n_fail++;
                $display("[TB] FAIL mult_out[%0d]: got %h/%h/%h expected %h/%h/%h",
                         c, out_instr, out_O, out_B, e.instr, e.o, e.b);
            end
        end
        n_checks++;
        if (stall_cnt != 17 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mult_stall_len: got %0d cycles busy=%b expected 17 cycles busy=0",
                     stall_cnt, busy);
        end
    endtask

    task automatic test_div_zero();
        logic        rdy;
        logic [31:0] b = 32'h0000_00B7;
        xm_t         e;
        for (int c = 0; c <= 6; c++) begin
            rdy = (c == 6);
            drive(DIV_W, 32'h0, b, rdy, 32'hA800_0005, rdy ? 32'd5 : 32'h0);
            n_checks++;
            if (stall !== !rdy) begin
                n_fail++;
                $display("[TB] FAIL divz_stall[%0d]: got %b expected %b", c, stall, !rdy);
            end
            exp_q.push_back(rdy ? {32'hA800_0005, 32'd5, b} : {NOP_W, 32'h0, 32'h0});
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({out_instr, out_O, out_B} !== e) begin
                n_fail++;
                $display("[TB] FAIL divz_out[%0d]: got %h/%h/%h expected %h/%h/%h",
                         c, out_instr, out_O, out_B, e.instr, e.o, e.b);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          idle_gap = 0;
        logic        rdy;
        logic        busy_exp;
        logic [31:0] instr;
        logic [31:0] res;
        logic [31:0] b = 32'h0BAD_BEEF;
        xm_t         e;
        for (int c = 0; c <= 10; c++) begin
            instr    = (c <= 5) ? MULT_W : DIV_W;
            rdy      = (c == 5) || (c == 10);
            res      = (c == 5) ? 32'h1111_0001 : 32'h2222_0002;
            busy_exp = !((c == 0) || (c == 6));
            drive(instr, 32'h0, b, rdy, instr, res);
            if (c >= 1 && !busy) idle_gap++;
            n_checks++;
            if (stall !== !rdy || busy !== busy_exp) begin
                n_fail++;
                $display("[TB] FAIL b2b_ctrl[%0d]: got stall=%b busy=%b expected %b/%b",
                         c, stall, busy, !rdy, busy_exp);
            end
            exp_q.push_back(rdy ? {instr, res, b} : {NOP_W, 32'h0, 32'h0});
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({out_instr, out_O, out_B} !== e) begin
                n_fail++;
                $display("[TB] FAIL b2b_out[%0d]: got %h/%h/%h expected %h/%h/%h",
                         c, out_instr, out_O, out_B, e.instr, e.o, e.b);
            end
        end
        n_checks++;
        if (idle_gap != 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_gap: got %0d idle cycles expected 1", idle_gap);
        end
    endtask

    task automatic test_reset_mid_busy();
        xm_t e;
        for (int c = 0; c < 8; c++) begin
            drive(MULT_W, 32'h0, 32'h7, 1'b0, MULT_W, 32'h0);
            exp_q.push_back({NOP_W, 32'h0, 32'h0});
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({out_instr, out_O, out_B} !== e) begin
                n_fail++;
                $display("[TB] FAIL rstbusy_out[%0d]: got %h/%h/%h expected %h/%h/%h",
                         c, out_instr, out_O, out_B, e.instr, e.o, e.b);
            end
        end
        drive(MULT_W, 32'h0, 32'h7, 1'b0, MULT_W, 32'h0);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_instr, out_O, out_B} !== {NOP_W, 32'h0, 32'h0} || stall !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rstbusy_clear: got %h/%h/%h stall=%b busy=%b expected 0/0/0 stall=0 busy=0",
                     out_instr, out_O, out_B, stall, busy);
        end
        advance();
        drive(NOP_W, 32'h0, 32'h0, 1'b0, NOP_W, 32'h0);
        reset = 1'b1;
        advance();
        drive(ADD_W, 32'h0000_0033, 32'h44, 1'b1, MULT_W, 32'hDEAD_DEAD);
        n_checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rstbusy_late_ctrl: got stall=%b busy=%b expected 0/0", stall, busy);
        end
        exp_q.push_back({ADD_W, 32'h0000_0033, 32'h44});
        advance();
        e = exp_q.pop_front();
        n_checks++;
        if ({out_instr, out_O, out_B} !== e || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rstbusy_late_ready: got %h/%h/%h busy=%b expected %h/%h/%h busy=0",
                     out_instr, out_O, out_B, busy, e.instr, e.o, e.b);
        end
        drive(NOP_W, 32'h0, 32'h0, 1'b0, NOP_W, 32'h0);
    endtask

    task automatic test_watchdog();
        logic [31:0] b = 32'h0000_0ABC;
        logic        stall_exp;
        xm_t         e;
        int          last;
`ifdef XM_MULTDIV_TIMEOUT_EN
        last = TMO;
`else
        last = 120;
`endif
        for (int c = 0; c <= last; c++) begin
`ifdef XM_MULTDIV_TIMEOUT_EN
            drive(MULT_W, 32'h0, b, 1'b0, MULT_W, 32'h0);
            stall_exp = (c < TMO);
            exp_q.push_back((c == TMO) ? {32'hA800_0006, 32'd6, b} : {NOP_W, 32'h0, 32'h0});
`else
            drive(MULT_W, 32'h0, b, (c == last), MULT_W, 32'h0000_5A5A);
            stall_exp = (c < last);
            exp_q.push_back((c == last) ? {MULT_W, 32'h0000_5A5A, b} : {NOP_W, 32'h0, 32'h0});
`endif
            n_checks++;
            if (stall !== stall_exp) begin
                n_fail++;
                $display("[TB] FAIL wdog_stall[%0d]: got %b expected %b", c, stall, stall_exp);
            end
            advance();
            e = exp_q.pop_front();
            n_checks++;
            if ({out_instr, out_O, out_B} !== e) begin
                n_fail++;
                $display("[TB] FAIL wdog_out[%0d]: got %h/%h/%h expected %h/%h/%h",
                         c, out_instr, out_O, out_B, e.instr, e.o, e.b);
            end
        end
        drive(ADD_W, 32'h0000_0077, 32'h88, 1'b1, DIV_W, 32'hDEAD_0000);
        exp_q.push_back({ADD_W, 32'h0000_0077, 32'h88});
        advance();
        e = exp_q.pop_front();
        n_checks++;
        if ({out_instr, out_O, out_B} !== e || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wdog_stray_ready: got %h/%h/%h busy=%b expected %h/%h/%h busy=0",
                     out_instr, out_O, out_B, busy, e.instr, e.o, e.b);
        end
    endtask

    initial begin
        test_reset();
        advance();
        test_alu();
        test_mult();
        test_div_zero();
        test_alu();
        test_back_to_back();
        test_reset_mid_busy();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] aborting");
    end

endmodule
